// File: rtl/video_stitch_pkg.sv
// Shared types and helpers for the video row stitcher: FSM encoding, default widths
// and a constant-evaluable clog2 for sizing counters and pointers.
package video_stitch_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stitch_line_fifo.sv
// Synchronous line FIFO with occupancy count. wr_ready is registered from the
// next-cycle occupancy so it is low while in reset and exactly tracks !full afterwards.
module stitch_line_fifo
    import video_stitch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic [clog2(DEPTH):0] count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;

    assign push    = wr_valid && wr_ready;
    assign pop     = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            wr_ready <= (count_next != FULL_CNT);
        end
    end

endmodule

// File: rtl/video_row_stitcher.sv
// Stitches a buffered-memory stream (A) and a live camera stream (B) into output rows
// of LINE_W A pixels followed by LINE_W B pixels, with SOL/EOL/EOF flags and a frame-done pulse.
//
// state  | meaning
// IDLE   | waiting until both line FIFOs hold a full source row
// SEND_A | popping A into the output register, col 0..LINE_W-1
// SEND_B | popping B into the output register, col LINE_W..2*LINE_W-1
module video_row_stitcher
    import video_stitch_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_W     = 16,
    parameter int N_LINES    = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              erst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sol,
    output logic              out_eol,
    output logic              out_eof,
    output logic              done
);

    localparam int COL_W = clog2(2 * LINE_W);
    localparam int ROW_W = (N_LINES > 1) ? clog2(N_LINES) : 1;
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] LINE_CNT   = CNT_W'(LINE_W);
    localparam logic [COL_W-1:0] COL_LAST_A = COL_W'(LINE_W - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(2 * LINE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N_LINES - 1);

    state_t            state;
    state_t            state_next;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_next;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_next;

    logic [CNT_W-1:0]  count_a;
    logic [CNT_W-1:0]  count_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              pop_a;
    logic              pop_b;
    logic              push_a;
    logic              push_b;
    logic              adv;
    logic              rows_ready;
    logic              rows_ready_after;

    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_sol;
    logic              ld_eol;
    logic              ld_eof;

    stitch_line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo_a (
        .clk      (clk),
        .rst_n    (erst_n),
        .clear    (clear),
        .wr_data  (a_data),
        .wr_valid (a_valid),
        .wr_ready (a_ready),
        .rd_en    (pop_a),
        .rd_data  (rd_a),
        .count    (count_a)
    );

    stitch_line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo_b (
        .clk      (clk),
        .rst_n    (erst_n),
        .clear    (clear),
        .wr_data  (b_data),
        .wr_valid (b_valid),
        .wr_ready (b_ready),
        .rd_en    (pop_b),
        .rd_data  (rd_b),
        .count    (count_b)
    );

    assign push_a = a_valid && a_ready;
    assign push_b = b_valid && b_ready;
    assign adv    = !out_valid || out_ready;

    assign rows_ready = (count_a >= LINE_CNT) && (count_b >= LINE_CNT);
    // At the last B pop, look at occupancy after this edge so consecutive rows run without a bubble.
    assign rows_ready_after = ((count_a + CNT_W'(push_a)) >= LINE_CNT) &&
                              ((count_b + CNT_W'(push_b)) > LINE_CNT);

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        pop_a      = 1'b0;
        pop_b      = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_sol     = 1'b0;
        ld_eol     = 1'b0;
        ld_eof     = 1'b0;
        case (state)
            IDLE: begin
                if (rows_ready) begin
                    state_next = SEND_A;
                end
            end
            SEND_A: begin
                if (adv) begin
                    pop_a    = 1'b1;
                    ld_valid = 1'b1;
                    ld_data  = rd_a;
                    ld_sol   = (col == '0);
                    col_next = col + COL_W'(1);
                    if (col == COL_LAST_A) begin
                        state_next = SEND_B;
                    end
                end
            end
            SEND_B: begin
                if (adv) begin
                    pop_b    = 1'b1;
                    ld_valid = 1'b1;
                    ld_data  = rd_b;
                    if (col == COL_LAST) begin
                        ld_eol     = 1'b1;
                        ld_eof     = (row == ROW_LAST);
                        col_next   = '0;
                        row_next   = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                        state_next = rows_ready_after ? SEND_A : IDLE;
                    end else begin
                        col_next = col + COL_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                col_next   = '0;
                row_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge erst_n) begin
        if (!erst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
            if (adv) begin
                out_valid <= ld_valid;
                out_data  <= ld_data;
                out_sol   <= ld_sol;
                out_eol   <= ld_eol;
                out_eof   <= ld_eof;
            end
        end
    end

    assign done = out_valid && out_ready && out_eof;

endmodule
